// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the button accumulator calculator.
package calc_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned SHAMT_W   = $clog2(DEF_WIDTH);
  localparam int unsigned CNT_W     = $clog2(DEF_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_LT  = 3'b100,
    OP_LSL = 3'b101,
    OP_ASR = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  function automatic int unsigned shamt_width(input int unsigned width);
    return $clog2(width);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/calc_acc_undo_if.sv
// Board-side signal bundle: buttons and switches in, LED bank and flags out.
interface calc_acc_undo_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             btnl;
  logic             btnc;
  logic             btnr;
  logic             btnd;
  logic             btn_undo;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] led;
  logic             ovf;
  logic             zero;
  logic [CNT_W-1:0] undo_cnt;

  modport master (
    output btnl, btnc, btnr, btnd, btn_undo, sw,
    input  led, ovf, zero, undo_cnt
  );

  modport slave (
    input  btnl, btnc, btnr, btnd, btn_undo, sw,
    output led, ovf, zero, undo_cnt
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU: one result per op select, plus signed overflow for ADD/SUB.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam int unsigned SH_W = shamt_width(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SH_W-1:0]  shamt;
  logic             lt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LT:  result = {{(WIDTH-1){1'b0}}, lt};
      OP_LSL: result = a << shamt;
      OP_ASR: result = WIDTH'($signed(a) >>> shamt);
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/calc_acc_undo.sv
// Accumulator calculator: edge-triggered execute and undo over a circular history.
module calc_acc_undo
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            btnu,
  calc_acc_undo_if.slave bus
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic             btnd_q;
  logic             undo_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hist [DEPTH];

  logic             exec_c;
  logic             undo_c;
  op_e              op_c;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  // Execute beats undo: a coincident undo edge is simply dropped.
  assign exec_c  = bus.btnd & ~btnd_q;
  assign undo_c  = bus.btn_undo & ~undo_q & (cnt_q != '0) & ~exec_c;
  assign op_c    = op_e'({bus.btnl, bus.btnc, bus.btnr});
  assign top_idx = (head_q == '0) ? LAST : head_q - PTR_W'(1);

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (acc_q),
    .b      (bus.sw),
    .op     (op_c),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // Next-state for accumulator, flag and history bookkeeping.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    if (exec_c) begin
      acc_d  = alu_res;
      ovf_d  = alu_ovf;
      head_d = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
      cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (undo_c) begin
      acc_d  = hist[top_idx];
      ovf_d  = 1'b0;
      head_d = top_idx;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (btnu) begin
      btnd_q <= 1'b0;
      undo_q <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
      cnt_q  <= '0;
    end else begin
      btnd_q <= bus.btnd;
      undo_q <= bus.btn_undo;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  // History storage is plain RAM; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (!btnu && exec_c) hist[head_q] <= acc_q;
  end

  assign bus.led      = acc_q;
  assign bus.ovf      = ovf_q;
  assign bus.undo_cnt = cnt_q;
  assign bus.zero     = (acc_q == '0);
endmodule

// File: tb/tb_calc_acc_undo.sv
// Directed bench for calc_acc_undo at WIDTH=16, DEPTH=4.
module tb_calc_acc_undo;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, SUB_ = 3'b011;
  localparam logic [2:0] LT_  = 3'b100, LSL_ = 3'b101, ASR_ = 3'b110, XOR_ = 3'b111;

  logic clk = 1'b0;
  logic btnu = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  calc_acc_undo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  calc_acc_undo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk  (clk),
    .btnu (btnu),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic [2:0] op);
    {bus.btnl, bus.btnc, bus.btnr} = op;
  endtask

  task automatic apply_reset();
    @(negedge clk); btnu = 1'b1;
    @(negedge clk); btnu = 1'b0;
  endtask

  // One press of execute, optionally with a coincident undo edge; result visible at the returning negedge.
  task automatic exec(input logic [2:0] op, input logic [W-1:0] b, input logic with_undo);
    @(negedge clk);
    set_op(op); bus.sw = b; bus.btnd = 1'b1; bus.btn_undo = with_undo;
    @(negedge clk);
    bus.btnd = 1'b0; bus.btn_undo = 1'b0; bus.sw = 16'hDEAD; set_op(AND_);
  endtask

  task automatic undo();
    @(negedge clk); bus.btn_undo = 1'b1;
    @(negedge clk); bus.btn_undo = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (bus.led !== 16'h0000 || bus.zero !== 1'b1 || bus.ovf !== 1'b0 || bus.undo_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: led=%h zero=%b ovf=%b cnt=%0d, want 0000 1 0 0", bus.led, bus.zero, bus.ovf, bus.undo_cnt);
    end
  endtask

  task automatic test_op_chain();
    logic [2:0]   ops [9] = '{ADD_, SUB_, OR_, AND_, XOR_, ADD_, LSL_, ASR_, LT_};
    logic [W-1:0] bs  [9] = '{16'h354A, 16'h1234, 16'h1001, 16'hF0F0, 16'h1FA2,
                              16'h6AA2, 16'h0004, 16'h0001, 16'h46FF};
    logic [W-1:0] exp [9] = '{16'h354A, 16'h2316, 16'h3317, 16'h3010, 16'h2FB2,
                              16'h9A54, 16'hA540, 16'hD2A0, 16'h0001};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      exec(ops[i], bs[i], 1'b0);
      vectors++;
      if (bus.led !== exp[i] || bus.zero !== 1'b0) begin
        miscompares++;
        $display("FAIL chain[%0d]: led=%h zero=%b, want %h 0", i, bus.led, bus.zero, exp[i]);
      end
    end
    // upper sw bits must not affect the shift amount
    exec(ADD_, 16'h00FF, 1'b0);
    exec(LSL_, 16'hFFF1, 1'b0);
    vectors++;
    if (bus.led !== 16'h0200) begin
      miscompares++;
      $display("FAIL shamt_mask: led=%h, want 0200", bus.led);
    end
  endtask

  task automatic test_edge_trigger();
    apply_reset();
    @(negedge clk);
    set_op(ADD_); bus.sw = 16'h0001; bus.btnd = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.led !== 16'h0001 || bus.undo_cnt !== 3'd1) begin
      miscompares++;
      $display("FAIL held_btnd: led=%h cnt=%0d, want 0001 1", bus.led, bus.undo_cnt);
    end
    bus.btnd = 1'b0;
    exec(ADD_, 16'h0001, 1'b0);
    vectors++;
    if (bus.led !== 16'h0002) begin
      miscompares++;
      $display("FAIL repress: led=%h, want 0002", bus.led);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    exec(ADD_, 16'h7FFF, 1'b0);
    exec(ADD_, 16'h0001, 1'b0);
    vectors++;
    if (bus.led !== 16'h8000 || bus.ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf: led=%h ovf=%b, want 8000 1", bus.led, bus.ovf);
    end
    exec(AND_, 16'hFFFF, 1'b0);
    vectors++;
    if (bus.led !== 16'h8000 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL and_clr: led=%h ovf=%b, want 8000 0", bus.led, bus.ovf);
    end
    exec(SUB_, 16'h0001, 1'b0);
    vectors++;
    if (bus.led !== 16'h7FFF || bus.ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_ovf: led=%h ovf=%b, want 7FFF 1", bus.led, bus.ovf);
    end
    undo();
    vectors++;
    if (bus.led !== 16'h8000 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL undo_ovf: led=%h ovf=%b, want 8000 0", bus.led, bus.ovf);
    end
  endtask

  task automatic test_undo_wrap();
    logic [W-1:0] exp_led [4] = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
    apply_reset();
    repeat (6) exec(ADD_, 16'h0001, 1'b0);
    vectors++;
    if (bus.led !== 16'h0006 || bus.undo_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL six_adds: led=%h cnt=%0d, want 0006 4", bus.led, bus.undo_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      undo();
      vectors++;
      if (bus.led !== exp_led[i] || bus.undo_cnt !== 3'(3 - i)) begin
        miscompares++;
        $display("FAIL undo[%0d]: led=%h cnt=%0d, want %h %0d", i, bus.led, bus.undo_cnt, exp_led[i], 3 - i);
      end
    end
    undo();
    vectors++;
    if (bus.led !== 16'h0002 || bus.undo_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL undo_empty: led=%h cnt=%0d, want 0002 0", bus.led, bus.undo_cnt);
    end
  endtask

  task automatic test_collisions();
    apply_reset();
    exec(ADD_, 16'h0003, 1'b0);
    exec(ADD_, 16'h0001, 1'b1);
    vectors++;
    if (bus.led !== 16'h0004 || bus.undo_cnt !== 3'd2) begin
      miscompares++;
      $display("FAIL exec_vs_undo: led=%h cnt=%0d, want 0004 2", bus.led, bus.undo_cnt);
    end
    // reset wins over a same-cycle execute edge, and that edge must not fire afterwards
    @(negedge clk);
    btnu = 1'b1; set_op(ADD_); bus.sw = 16'h0011; bus.btnd = 1'b1;
    @(negedge clk);
    btnu = 1'b0; bus.btnd = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.led !== 16'h0000 || bus.undo_cnt !== 3'd0 || bus.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_vs_exec: led=%h cnt=%0d zero=%b, want 0000 0 1", bus.led, bus.undo_cnt, bus.zero);
    end
  endtask

  initial begin
    bus.btnl = 1'b0; bus.btnc = 1'b0; bus.btnr = 1'b0;
    bus.btnd = 1'b0; bus.btn_undo = 1'b0; bus.sw = '0;
    test_reset();
    test_op_chain();
    test_edge_trigger();
    test_overflow();
    test_undo_wrap();
    test_collisions();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/calc_acc_undo.md
# calc_acc_undo

Parametrised successor to the 16-bit button calculator: a WIDTH-bit accumulator ALU driven by the board buttons and switches, with edge-triggered execute, signed-overflow and zero flags, and a DEPTH-entry undo history. It sits between the board I/O (buttons, switches) and the LED bank at the top level of the board design.

## Interface
- WIDTH, 16: accumulator, operand and LED width; at least 4.
- DEPTH, 4: undo history entries; at least 1.
- clk  in  1  system clock; all state on the rising edge.
- btnu  in  1  synchronous, active-high reset.
- btnl, btnc, btnr  in  1 each  op select, {btnl,btnc,btnr}.
- btnd  in  1  execute; acts on its rising edge only.
- btn_undo  in  1  undo; acts on its rising edge only.
- sw  in  WIDTH  operand B.
- led  out  WIDTH  accumulator value.
- ovf  out  1  signed overflow of the last executed op.
- zero  out  1  set when the accumulator is 0.
- undo_cnt  out  $clog2(DEPTH+1)  number of valid history entries.

## Operation
- Op encoding {l,c,r}:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 SUB (acc − sw)
  - 100 signed LT (result is 1 if acc < sw signed, else 0, zero-extended)
  - 101 LSL by sw[$clog2(WIDTH)-1:0]
  - 110 ASR by sw[$clog2(WIDTH)-1:0]
  - 111 XOR
- Shift amount: upper sw bits are ignored for shifts.
- Arithmetic is modulo 2^WIDTH.
- ovf:
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from acc.
  - All other ops: cleared.
- Edge detect: each button has a previous-value register, cleared to 0 by reset. A button held high across reset deassertion therefore fires once.
- Execute on a btnd edge:
  - Push the current acc onto the history; when DEPTH entries are already held, the oldest entry is discarded (circular buffer).
  - Load acc with the ALU result.
  - Update ovf.
- Undo on a btn_undo edge with undo_cnt > 0:
  - Pop the newest entry into acc.
  - Clear ovf.
  - Decrement undo_cnt.
- Undo on a btn_undo edge with undo_cnt = 0: no effect.
- Simultaneous btnd and btn_undo edges: execute wins and the undo edge is consumed (dropped).
- zero is combinational from acc.

## Timing
- Reset (btnu high at a clock edge): acc=0, led=0, ovf=0, zero=1, undo_cnt=0, history pointers=0, edge registers=0. Reset overrides any same-cycle button edge.
- Execute latency: button high at clock edge N (low at N−1) → led, ovf and undo_cnt updated after edge N. One op per press; holding the button performs nothing further.
- Undo latency: identical, 1 cycle.
- Op select and sw are sampled at the edge where the btnd edge is detected; changes on other cycles have no effect.
- No handshake; buttons are assumed already debounced and synchronised upstream.

## Structure
- calc_pkg: op enum (OP_AND … OP_XOR), localparams for the shift-amount width and the undo_cnt width.
- Sub-module calc_alu: purely combinational. Inputs a, b, op; outputs result and ovf; parametrised on WIDTH.
- Top block holds the edge detectors, the accumulator, and the history RAM with its head pointer and count.

## Test plan
- Reset: btnu high one cycle → led=0000, zero=1, ovf=0, undo_cnt=0.
- Op chain (WIDTH=16), each op applied to the result of the previous:
  - ADD 354A → 354A
  - SUB 1234 → 2316
  - OR 1001 → 3317
  - AND F0F0 → 3010
  - XOR 1FA2 → 2FB2
  - ADD 6AA2 → 9A54
  - LSL 0004 → A540
  - ASR 0001 → D2A0
  - LT 46FF → 0001
- Edge trigger: from acc=0, ADD with sw=0001 and btnd held 5 cycles → led=0001; release then press again → 0002.
- Overflow: acc=7FFF, ADD 0001 → led=8000, ovf=1; then AND FFFF → ovf=0. acc=8000, SUB 0001 → 7FFF, ovf=1.
- Undo with wrap (DEPTH=4): six ADD 0001 ops from 0 → led=0006, undo_cnt=4. Four undos → led=0002, undo_cnt=0. A fifth undo → no change.
- Collisions:
  - btnd and btn_undo edges in the same cycle → execute only; undo_cnt increments.
  - Reset asserted in the same cycle as a btnd edge → led=0000.
